// File: rtl/dosing_ctrl_pkg.sv
// ============================================================================
// dosing_ctrl_pkg
// Shared state encoding, channel bit indices and command helpers for dosing.
// Revision: 1.0
// ============================================================================
`default_nettype none

package dosing_ctrl_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_RUN    = 2'd1;
    localparam logic [STATE_W-1:0] ST_SETTLE = 2'd2;
    localparam logic [STATE_W-1:0] ST_DONE   = 2'd3;

    // Bit positions shared with the sequencer's motores encoding.
    localparam int CH_R = 2;
    localparam int CH_G = 1;
    localparam int CH_B = 0;

    function automatic logic is_onehot3(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

endpackage

`default_nettype wire

// File: rtl/dosing_ctrl_tick_gen.sv
// ============================================================================
// dosing_ctrl_tick_gen
// Dose-tick prescaler: one-cycle tick every TICK_DIV enabled cycles.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dosing_ctrl_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int               PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    logic [PRE_W-1:0] pre_q;
    logic [PRE_W-1:0] pre_d;

    always_comb begin
        pre_d = pre_q;
        if (clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = en && (pre_q == PRE_LAST);

endmodule

`default_nettype wire

// File: rtl/dosing_ctrl.sv
// ============================================================================
// dosing_ctrl
// Runs the commanded pump for amount ticks, settles, then flags completion.
// Revision: 1.0
// ============================================================================
`default_nettype none

module dosing_ctrl
    import dosing_ctrl_pkg::*;
#(
    parameter int TICK_DIV     = 50000,
    parameter int AMT_W        = 8,
    parameter int SETTLE_TICKS = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       motores,
    input  logic [AMT_W-1:0] amount_r,
    input  logic [AMT_W-1:0] amount_g,
    input  logic [AMT_W-1:0] amount_b,
    output logic [2:0]       motor_en,
    output logic [2:0]       flags,
    output logic             busy,
    output logic             error
);

    localparam int               SET_W      = $clog2(SETTLE_TICKS + 1);
    localparam int               CNT_W      = (AMT_W > SET_W) ? AMT_W : SET_W;
    localparam logic [CNT_W-1:0] SETTLE_END = CNT_W'(SETTLE_TICKS);

    logic [STATE_W-1:0] state_q, state_d;
    logic [2:0]         cmd_q, cmd_d;
    logic [AMT_W-1:0]   amt_q, amt_d;
    logic [CNT_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [2:0]         motor_en_q, motor_en_d;
    logic [2:0]         flags_q, flags_d;
    logic               busy_q, busy_d;
    logic               error_q, error_d;

    logic               w_valid;
    logic               w_tick;
    logic               w_clr;
    logic               w_tick_en;
    logic [AMT_W-1:0]   w_amt_sel;
    logic [CNT_W-1:0]   w_tick_nxt;

    assign w_tick_en = (state_q == ST_RUN) || (state_q == ST_SETTLE);

    dosing_ctrl_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .en    (w_tick_en),
        .clr   (w_clr),
        .tick  (w_tick)
    );

    always_comb begin
        w_valid    = is_onehot3(motores);
        w_tick_nxt = tick_cnt_q + CNT_W'(1);
        if (motores[CH_R]) begin
            w_amt_sel = amount_r;
        end else if (motores[CH_G]) begin
            w_amt_sel = amount_g;
        end else begin
            w_amt_sel = amount_b;
        end

        state_d    = state_q;
        cmd_d      = cmd_q;
        amt_d      = amt_q;
        tick_cnt_d = tick_cnt_q;
        w_clr      = 1'b0;

        // Every state change restarts both the prescaler and the tick count.
        case (state_q)
            ST_IDLE: begin
                w_clr      = 1'b1;
                tick_cnt_d = '0;
                if (w_valid) begin
                    cmd_d   = motores;
                    amt_d   = w_amt_sel;
                    state_d = (w_amt_sel != '0) ? ST_RUN : ST_SETTLE;
                end
            end
            ST_RUN: begin
                if (motores != cmd_q) begin
                    state_d    = ST_IDLE;
                    w_clr      = 1'b1;
                    tick_cnt_d = '0;
                end else if (w_tick) begin
                    if (w_tick_nxt == CNT_W'(amt_q)) begin
                        state_d    = ST_SETTLE;
                        w_clr      = 1'b1;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = w_tick_nxt;
                    end
                end
            end
            ST_SETTLE: begin
                if (motores != cmd_q) begin
                    state_d    = ST_IDLE;
                    w_clr      = 1'b1;
                    tick_cnt_d = '0;
                end else if (w_tick) begin
                    if (w_tick_nxt == SETTLE_END) begin
                        state_d    = ST_DONE;
                        w_clr      = 1'b1;
                        tick_cnt_d = '0;
                    end else begin
                        tick_cnt_d = w_tick_nxt;
                    end
                end
            end
            ST_DONE: begin
                if (motores != cmd_q) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                w_clr      = 1'b1;
                tick_cnt_d = '0;
            end
        endcase

        motor_en_d = (state_d == ST_RUN)  ? cmd_d : 3'b000;
        flags_d    = (state_d == ST_DONE) ? cmd_d : 3'b000;
        busy_d     = (state_d == ST_RUN) || (state_d == ST_SETTLE);
        error_d    = (motores != 3'b000) && !w_valid;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cmd_q      <= '0;
            amt_q      <= '0;
            tick_cnt_q <= '0;
            motor_en_q <= '0;
            flags_q    <= '0;
            busy_q     <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            amt_q      <= amt_d;
            tick_cnt_q <= tick_cnt_d;
            motor_en_q <= motor_en_d;
            flags_q    <= flags_d;
            busy_q     <= busy_d;
            error_q    <= error_d;
        end
    end

    assign motor_en = motor_en_q;
    assign flags    = flags_q;
    assign busy     = busy_q;
    assign error    = error_q;

endmodule

`default_nettype wire

// File: tb/tb_dosing_ctrl.sv
// ============================================================================
// tb_dosing_ctrl
// Directed self-checking bench for dosing_ctrl (TICK_DIV=4, SETTLE_TICKS=2).
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_dosing_ctrl;

    logic       clk;
    logic       reset;
    logic [2:0] motores;
    logic [7:0] amount_r;
    logic [7:0] amount_g;
    logic [7:0] amount_b;
    logic [2:0] motor_en;
    logic [2:0] flags;
    logic       busy;
    logic       error;

    int total;
    int bad;

    dosing_ctrl #(
        .TICK_DIV     (4),
        .AMT_W        (8),
        .SETTLE_TICKS (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .motores  (motores),
        .amount_r (amount_r),
        .amount_g (amount_g),
        .amount_b (amount_b),
        .motor_en (motor_en),
        .flags    (flags),
        .busy     (busy),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int         pulse [3];
        int         fcount [3];
        logic [2:0] prev_flags;
        int         overlap;
        int         wait_cyc;
        logic [2:0] seq_cmd [3];

        total    = 0;
        bad      = 0;
        reset    = 1'b0;
        motores  = 3'b000;
        amount_r = 8'd0;
        amount_g = 8'd0;
        amount_b = 8'd0;
        #2;
        chk("rst_motor", 32'(motor_en), 32'h0);
        chk("rst_flags", 32'(flags), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        step();
        step();
        reset = 1'b1;
        step();

        // Scenario 1: reset during RUN, then restart from zero.
        motores  = 3'b100;
        amount_r = 8'd3;
        repeat (6) step();
        chk("s1_pre_motor", 32'(motor_en), 32'h4);
        reset = 1'b0;
        #2;
        chk("s1_async_motor", 32'(motor_en), 32'h0);
        chk("s1_async_flags", 32'(flags), 32'h0);
        chk("s1_async_busy", 32'(busy), 32'h0);
        chk("s1_async_error", 32'(error), 32'h0);
        step();
        reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("s1_run_motor", 32'(motor_en), 32'h4);
        end
        step();
        chk("s1_off_motor", 32'(motor_en), 32'h0);
        motores = 3'b000;
        step();
        step();

        // Scenario 2: red dose of 3 ticks.
        motores  = 3'b100;
        amount_r = 8'd3;
        for (int i = 0; i < 12; i++) begin
            step();
            chk("s2_run_motor", 32'(motor_en), 32'h4);
            chk("s2_run_busy", 32'(busy), 32'h1);
            if (i == 2) amount_r = 8'd1;
        end
        for (int i = 0; i < 8; i++) begin
            step();
            chk("s2_settle_motor", 32'(motor_en), 32'h0);
            chk("s2_settle_flags", 32'(flags), 32'h0);
        end
        step();
        chk("s2_flag", 32'(flags), 32'h4);
        chk("s2_done_busy", 32'(busy), 32'h0);
        step();
        chk("s2_flag_hold", 32'(flags), 32'h4);
        motores = 3'b000;
        step();
        chk("s2_flag_clear", 32'(flags), 32'h0);

        // Scenario 3: green with zero amount goes straight to settle.
        motores  = 3'b010;
        amount_g = 8'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("s3_busy", 32'(busy), 32'h1);
            chk("s3_motor", 32'(motor_en), 32'h0);
            chk("s3_flags", 32'(flags), 32'h0);
        end
        step();
        chk("s3_flag", 32'(flags), 32'h2);
        chk("s3_busy_end", 32'(busy), 32'h0);
        motores = 3'b000;
        step();
        chk("s3_flag_clear", 32'(flags), 32'h0);

        // Scenario 4: blue aborted at cycle 7.
        motores  = 3'b001;
        amount_b = 8'd5;
        for (int i = 0; i < 7; i++) begin
            step();
            chk("s4_motor", 32'(motor_en), 32'h1);
        end
        motores = 3'b000;
        step();
        chk("s4_abort_motor", 32'(motor_en), 32'h0);
        chk("s4_abort_busy", 32'(busy), 32'h0);
        for (int i = 0; i < 30; i++) begin
            step();
            chk("s4_no_flag", 32'(flags), 32'h0);
        end

        // Scenario 5: invalid multi-hot command.
        motores = 3'b110;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s5_error", 32'(error), 32'h1);
            chk("s5_motor", 32'(motor_en), 32'h0);
            chk("s5_flags", 32'(flags), 32'h0);
            chk("s5_busy", 32'(busy), 32'h0);
        end
        motores  = 3'b100;
        amount_r = 8'd1;
        step();
        chk("s5_error_clear", 32'(error), 32'h0);
        chk("s5_start_motor", 32'(motor_en), 32'h4);
        motores = 3'b000;
        step();
        chk("s5_abort_motor", 32'(motor_en), 32'h0);
        step();

        // Scenario 6: sequencer model 100 -> 010 -> 001.
        amount_r   = 8'd2;
        amount_g   = 8'd1;
        amount_b   = 8'd3;
        seq_cmd[0] = 3'b100;
        seq_cmd[1] = 3'b010;
        seq_cmd[2] = 3'b001;
        overlap    = 0;
        prev_flags = 3'b000;
        for (int c = 0; c < 3; c++) begin
            pulse[c]  = 0;
            fcount[c] = 0;
        end
        for (int c = 0; c < 3; c++) begin
            motores  = seq_cmd[c];
            wait_cyc = 0;
            while (((flags & seq_cmd[c]) == 3'b000) && wait_cyc < 200) begin
                step();
                wait_cyc++;
                if (motor_en == seq_cmd[c]) pulse[c]++;
                if ((motor_en & (motor_en - 3'd1)) != 3'b000) overlap++;
                for (int b = 0; b < 3; b++) begin
                    if (flags[2-b] && !prev_flags[2-b]) fcount[b]++;
                end
                prev_flags = flags;
            end
            chk("s6_flag_timeout", 32'(wait_cyc < 200), 32'h1);
        end
        motores = 3'b000;
        for (int i = 0; i < 10; i++) begin
            step();
            for (int b = 0; b < 3; b++) begin
                if (flags[2-b] && !prev_flags[2-b]) fcount[b]++;
            end
            prev_flags = flags;
        end
        chk("s6_pulse_r", 32'(pulse[0]), 32'd8);
        chk("s6_pulse_g", 32'(pulse[1]), 32'd4);
        chk("s6_pulse_b", 32'(pulse[2]), 32'd12);
        chk("s6_fcount_r", 32'(fcount[0]), 32'd1);
        chk("s6_fcount_g", 32'(fcount[1]), 32'd1);
        chk("s6_fcount_b", 32'(fcount[2]), 32'd1);
        chk("s6_overlap", 32'(overlap), 32'd0);
        chk("s6_final_flags", 32'(flags), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
